regfile_write_arbiter: RTL and testbench

REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

---
 rtl/regfile_write_arbiter_if.sv | 34 +++
 rtl/regfile_write_arbiter.sv | 201 ++++++++++++++++++++
 tb/tb_regfile_write_arbiter.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/regfile_write_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : regfile_write_arbiter_if
// Brief    : Requester/write-port bundle for the register-file write arbiter.
//            The master side drives requests and the slave side answers with
//            ready, the write strobe and the busy mask.
// Revision : 1.0  initial release
// ============================================================================
interface regfile_write_arbiter_if;
  logic        a_valid;
  logic [4:0]  a_rd;
  logic [31:0] a_data;
  logic        a_ready;
  logic        b_valid;
  logic [4:0]  b_rd;
  logic [31:0] b_data;
  logic        b_ready;
  logic        flush_a;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic [31:0] busy_mask;

  modport master (
    output a_valid, a_rd, a_data, b_valid, b_rd, b_data, flush_a,
    input  a_ready, b_ready, wr_en, wr_addr, wr_data, busy_mask
  );

  modport slave (
    input  a_valid, a_rd, a_data, b_valid, b_rd, b_data, flush_a,
    output a_ready, b_ready, wr_en, wr_addr, wr_data, busy_mask
  );
endinterface
`default_nettype wire

// File: rtl/regfile_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : regfile_write_arbiter
// Brief    : Shares one register-file write port between an EX-stage
//            requester (A) and a MEM-stage requester (B). Each requester has
//            a 2-entry FIFO; heads are arbitrated round-robin, with B winning
//            when both heads target the same register. Provides a per-register
//            pending-write mask.
// Revision : 1.0  initial release
// ============================================================================
module regfile_write_arbiter (
  input  wire logic               clk,
  input  wire logic               rst,
  regfile_write_arbiter_if.slave  bus
);

  localparam int c_RD_W   = 5;
  localparam int c_DATA_W = 32;

  // Requester A queue
  logic [c_RD_W-1:0]   r_a_rd   [2];
  logic [c_DATA_W-1:0] r_a_data [2];
  logic                r_a_rptr;
  logic                r_a_wptr;
  logic [1:0]          r_a_cnt;

  // Requester B queue
  logic [c_RD_W-1:0]   r_b_rd   [2];
  logic [c_DATA_W-1:0] r_b_data [2];
  logic                r_b_rptr;
  logic                r_b_wptr;
  logic [1:0]          r_b_cnt;

  // Round-robin history: 1 means B was granted last
  logic                r_last_b;

  // Registered write port
  logic                r_wr_en;
  logic [c_RD_W-1:0]   r_wr_addr;
  logic [c_DATA_W-1:0] r_wr_data;

  logic                w_a_ready;
  logic                w_b_ready;
  logic                w_a_push;
  logic                w_b_push;
  logic                w_a_elig;
  logic                w_b_elig;
  logic                w_grant_a;
  logic                w_grant_b;
  logic                w_grant;
  logic                w_upd_last;
  logic [c_RD_W-1:0]   w_a_head_rd;
  logic [c_RD_W-1:0]   w_b_head_rd;
  logic [c_RD_W-1:0]   w_sel_rd;
  logic [c_DATA_W-1:0] w_sel_data;
  logic [31:0]         w_busy;

  // Ready reflects occupancy before the edge, so a full queue refuses a push
  // even when it is being popped in the same cycle.
  assign w_a_ready = (r_a_cnt != 2'd2);
  assign w_b_ready = (r_b_cnt != 2'd2);

  // A flush drops any A push presented on the same edge.
  assign w_a_push  = bus.a_valid && w_a_ready && !bus.flush_a;
  assign w_b_push  = bus.b_valid && w_b_ready;

  assign w_a_head_rd = r_a_rd[r_a_rptr];
  assign w_b_head_rd = r_b_rd[r_b_rptr];

  // Pick the head to retire this cycle; a flushed A head is not eligible.
  always_comb begin
    w_a_elig   = (r_a_cnt != 2'd0) && !bus.flush_a;
    w_b_elig   = (r_b_cnt != 2'd0);
    w_grant_a  = 1'b0;
    w_grant_b  = 1'b0;
    w_upd_last = 1'b0;
    if (w_a_elig && w_b_elig) begin
      if (w_a_head_rd == w_b_head_rd) begin
        // Same destination: B carries the older instruction, history untouched
        w_grant_b = 1'b1;
      end else begin
        w_upd_last = 1'b1;
        if (r_last_b) begin
          w_grant_a = 1'b1;
        end else begin
          w_grant_b = 1'b1;
        end
      end
    end else if (w_a_elig) begin
      w_grant_a  = 1'b1;
      w_upd_last = 1'b1;
    end else if (w_b_elig) begin
      w_grant_b  = 1'b1;
      w_upd_last = 1'b1;
    end
  end

  assign w_grant    = w_grant_a || w_grant_b;
  assign w_sel_rd   = w_grant_b ? w_b_head_rd : w_a_head_rd;
  assign w_sel_data = w_grant_b ? r_b_data[r_b_rptr] : r_a_data[r_a_rptr];

  // Requester A FIFO: push/pop bookkeeping, emptied outright by flush_a
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        r_a_rd[i]   <= '0;
        r_a_data[i] <= '0;
      end
      r_a_rptr <= 1'b0;
      r_a_wptr <= 1'b0;
      r_a_cnt  <= 2'd0;
    end else if (bus.flush_a) begin
      r_a_rptr <= 1'b0;
      r_a_wptr <= 1'b0;
      r_a_cnt  <= 2'd0;
    end else begin
      if (w_a_push) begin
        r_a_rd[r_a_wptr]   <= bus.a_rd;
        r_a_data[r_a_wptr] <= bus.a_data;
        r_a_wptr           <= ~r_a_wptr;
      end
      if (w_grant_a) begin
        r_a_rptr <= ~r_a_rptr;
      end
      r_a_cnt <= r_a_cnt + {1'b0, w_a_push} - {1'b0, w_grant_a};
    end
  end

  // Requester B FIFO: push/pop bookkeeping
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        r_b_rd[i]   <= '0;
        r_b_data[i] <= '0;
      end
      r_b_rptr <= 1'b0;
      r_b_wptr <= 1'b0;
      r_b_cnt  <= 2'd0;
    end else begin
      if (w_b_push) begin
        r_b_rd[r_b_wptr]   <= bus.b_rd;
        r_b_data[r_b_wptr] <= bus.b_data;
        r_b_wptr           <= ~r_b_wptr;
      end
      if (w_grant_b) begin
        r_b_rptr <= ~r_b_rptr;
      end
      r_b_cnt <= r_b_cnt + {1'b0, w_b_push} - {1'b0, w_grant_b};
    end
  end

  // Round-robin history; reset to B so A wins the first contest
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last_b <= 1'b1;
    end else if (w_upd_last) begin
      r_last_b <= w_grant_b;
    end
  end

  // Register the granted write; x0 grants retire silently and leave addr/data
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
    end else begin
      r_wr_en <= w_grant && (w_sel_rd != '0);
      if (w_grant && (w_sel_rd != '0)) begin
        r_wr_addr <= w_sel_rd;
        r_wr_data <= w_sel_data;
      end
    end
  end

  // Pending-write mask over both queues and the in-flight write; x0 never busy
  always_comb begin
    w_busy = '0;
    for (int i = 0; i < 2; i++) begin
      if ((r_a_cnt == 2'd2) || ((r_a_cnt == 2'd1) && (r_a_rptr == i[0]))) begin
        w_busy[r_a_rd[i]] = 1'b1;
      end
      if ((r_b_cnt == 2'd2) || ((r_b_cnt == 2'd1) && (r_b_rptr == i[0]))) begin
        w_busy[r_b_rd[i]] = 1'b1;
      end
    end
    if (r_wr_en) begin
      w_busy[r_wr_addr] = 1'b1;
    end
    w_busy[0] = 1'b0;
  end

  assign bus.a_ready   = w_a_ready;
  assign bus.b_ready   = w_b_ready;
  assign bus.wr_en     = r_wr_en;
  assign bus.wr_addr   = r_wr_addr;
  assign bus.wr_data   = r_wr_data;
  assign bus.busy_mask = w_busy;

endmodule
`default_nettype wire

// File: tb/tb_regfile_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_write_arbiter
// Brief    : Directed self-checking bench for regfile_write_arbiter.
// Revision : 1.0  initial release
// ============================================================================
module tb_regfile_write_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  regfile_write_arbiter_if bus ();

  regfile_write_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Advance past the next rising edge and settle before sampling/driving
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic chk_wr(input string tag, input logic en, input logic [4:0] addr,
                        input logic [31:0] data);
    chk({tag, ".wr_en"},   {31'd0, bus.wr_en}, {31'd0, en});
    chk({tag, ".wr_addr"}, {27'd0, bus.wr_addr}, {27'd0, addr});
    chk({tag, ".wr_data"}, bus.wr_data, data);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.a_valid = 1'b0; bus.a_rd = '0; bus.a_data = '0;
    bus.b_valid = 1'b0; bus.b_rd = '0; bus.b_data = '0;
    bus.flush_a = 1'b0;

    // ---- reset state ----
    #1 rst = 1'b1;
    #1;
    chk_wr("reset", 1'b0, 5'd0, 32'h0);
    chk("reset.busy", bus.busy_mask, 32'h0);
    chk("reset.a_ready", {31'd0, bus.a_ready}, 32'd1);
    chk("reset.b_ready", {31'd0, bus.b_ready}, 32'd1);
    tick(); tick();
    rst = 1'b0;

    // ---- round-robin A3/B4, two each ----
    bus.a_valid = 1'b1; bus.a_rd = 5'd3; bus.a_data = 32'hA000_0000;
    bus.b_valid = 1'b1; bus.b_rd = 5'd4; bus.b_data = 32'hB000_0000;
    tick();
    bus.a_data = 32'hA000_0001; bus.b_data = 32'hB000_0001;
    chk("rr.e0.wr_en", {31'd0, bus.wr_en}, 32'd0);
    tick();
    bus.a_valid = 1'b0; bus.b_valid = 1'b0;
    chk_wr("rr.w1", 1'b1, 5'd3, 32'hA000_0000);
    chk("rr.w1.busy", bus.busy_mask, 32'h0000_0018);
    chk("rr.w1.b_ready", {31'd0, bus.b_ready}, 32'd0);
    tick();
    chk_wr("rr.w2", 1'b1, 5'd4, 32'hB000_0000);
    tick();
    chk_wr("rr.w3", 1'b1, 5'd3, 32'hA000_0001);
    tick();
    chk_wr("rr.w4", 1'b1, 5'd4, 32'hB000_0001);
    tick();
    chk_wr("rr.idle", 1'b0, 5'd4, 32'hB000_0001);
    chk("rr.idle.busy", bus.busy_mask, 32'h0);

    // ---- same-rd tie: B first, history untouched so A wins next contest ----
    bus.a_valid = 1'b1; bus.a_rd = 5'd7; bus.a_data = 32'h1;
    bus.b_valid = 1'b1; bus.b_rd = 5'd7; bus.b_data = 32'h2;
    tick();
    bus.a_valid = 1'b0;
    bus.b_rd = 5'd8; bus.b_data = 32'h3;
    chk("tie.e0.busy", bus.busy_mask, 32'h0000_0080);
    tick();
    bus.b_valid = 1'b0;
    chk_wr("tie.w1", 1'b1, 5'd7, 32'h2);
    chk("tie.w1.busy", bus.busy_mask, 32'h0000_0180);
    tick();
    chk_wr("tie.w2", 1'b1, 5'd7, 32'h1);
    tick();
    chk_wr("tie.w3", 1'b1, 5'd8, 32'h3);
    tick();
    chk("tie.idle.wr_en", {31'd0, bus.wr_en}, 32'd0);

    // ---- single A write, latency and busy window ----
    bus.a_valid = 1'b1; bus.a_rd = 5'd5; bus.a_data = 32'h1234_5678;
    chk("single.pre.busy", bus.busy_mask, 32'h0);
    tick();
    bus.a_valid = 1'b0;
    chk("single.e0.busy", bus.busy_mask, 32'h0000_0020);
    chk("single.e0.wr_en", {31'd0, bus.wr_en}, 32'd0);
    tick();
    chk_wr("single.e1", 1'b1, 5'd5, 32'h1234_5678);
    chk("single.e1.busy", bus.busy_mask, 32'h0000_0020);
    tick();
    chk_wr("single.e2", 1'b0, 5'd5, 32'h1234_5678);
    chk("single.e2.busy", bus.busy_mask, 32'h0);

    // ---- A backpressure: ties keep B winning while A fills ----
    bus.a_valid = 1'b1; bus.a_rd = 5'd9; bus.a_data = 32'hC1;
    bus.b_valid = 1'b1; bus.b_rd = 5'd9; bus.b_data = 32'hB1;
    tick();
    bus.a_data = 32'hC2; bus.b_data = 32'hB2;
    tick();
    bus.a_data = 32'hC3; bus.b_valid = 1'b0;
    chk("bp.e1.a_ready", {31'd0, bus.a_ready}, 32'd0);
    chk_wr("bp.e1", 1'b1, 5'd9, 32'hB1);
    tick();
    chk("bp.e2.a_ready", {31'd0, bus.a_ready}, 32'd0);
    chk_wr("bp.e2", 1'b1, 5'd9, 32'hB2);
    tick();
    chk("bp.e3.a_ready", {31'd0, bus.a_ready}, 32'd1);
    chk_wr("bp.e3", 1'b1, 5'd9, 32'hC1);
    tick();
    bus.a_valid = 1'b0;
    chk_wr("bp.e4", 1'b1, 5'd9, 32'hC2);
    tick();
    chk_wr("bp.e5", 1'b1, 5'd9, 32'hC3);
    tick();
    chk("bp.e6.wr_en", {31'd0, bus.wr_en}, 32'd0);
    chk("bp.e6.busy", bus.busy_mask, 32'h0);

    // ---- flush_a with A full and a same-edge A push ----
    bus.a_valid = 1'b1; bus.a_rd = 5'd10; bus.a_data = 32'hD1;
    bus.b_valid = 1'b1; bus.b_rd = 5'd10; bus.b_data = 32'hE1;
    tick();
    bus.a_data = 32'hD2;
    bus.b_rd = 5'd11; bus.b_data = 32'hE2;
    tick();
    bus.a_rd = 5'd12; bus.a_data = 32'hD3;
    bus.flush_a = 1'b1; bus.b_valid = 1'b0;
    chk("fl.pre.a_ready", {31'd0, bus.a_ready}, 32'd0);
    chk("fl.pre.busy", bus.busy_mask, 32'h0000_0C00);
    tick();
    bus.flush_a = 1'b0; bus.a_valid = 1'b0;
    chk_wr("fl.e2", 1'b1, 5'd11, 32'hE2);
    chk("fl.e2.a_ready", {31'd0, bus.a_ready}, 32'd1);
    chk("fl.e2.busy", bus.busy_mask, 32'h0000_0800);
    tick();
    chk_wr("fl.e3", 1'b0, 5'd11, 32'hE2);
    chk("fl.e3.busy", bus.busy_mask, 32'h0);
    tick();
    chk("fl.e4.wr_en", {31'd0, bus.wr_en}, 32'd0);

    // ---- asynchronous reset mid-stream ----
    bus.a_valid = 1'b1; bus.a_rd = 5'd13; bus.a_data = 32'hFACE;
    bus.b_valid = 1'b1; bus.b_rd = 5'd14; bus.b_data = 32'hBEEF;
    tick();
    bus.a_valid = 1'b0; bus.b_valid = 1'b0;
    tick();
    chk_wr("ar.pre", 1'b1, 5'd13, 32'hFACE);
    chk("ar.pre.busy", bus.busy_mask, 32'h0000_6000);
    #2 rst = 1'b1;
    #1;
    chk_wr("ar.async", 1'b0, 5'd0, 32'h0);
    chk("ar.async.busy", bus.busy_mask, 32'h0);
    #1 rst = 1'b0;
    tick();
    chk("ar.lost.wr_en", {31'd0, bus.wr_en}, 32'd0);
    chk("ar.lost.busy", bus.busy_mask, 32'h0);

    // ---- rd=0 request retires with no write ----
    bus.a_valid = 1'b1; bus.a_rd = 5'd0; bus.a_data = 32'hDEAD;
    tick();
    bus.a_valid = 1'b0;
    chk("x0.e0.busy", bus.busy_mask, 32'h0);
    tick();
    chk_wr("x0.e1", 1'b0, 5'd0, 32'h0);
    chk("x0.e1.a_ready", {31'd0, bus.a_ready}, 32'd1);
    tick();
    chk_wr("x0.e2", 1'b0, 5'd0, 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
